axis_stream_scheduler: RTL

- Round-robin scheduler that shares one throttled AXI-Stream datapath between NUM_SOURCES sample producers (e.g. position and velocity channels).
- Grants one source at a time for a fixed burst of beats and forwards its beats to the downstream throttler.
- Owns the throttler's log_throttle configuration and applies new values only between bursts, so a decimation ratio never changes mid-burst.

---
 rtl/vibrometer_axis_pkg.sv | 37 +++
 rtl/axis_stream_scheduler_rr_arbiter.sv | 43 ++++
 rtl/axis_stream_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vibrometer_axis_pkg.sv
// rtl/vibrometer_axis_pkg.sv - shared types, constants and round-robin helper for the AXI-Stream scheduler
// Contents:
//   state_t            scheduler FSM states (IDLE, GRANT)
//   LOG_THROTTLE_WIDTH width of the throttler exponent
//   MAX_SOURCES        largest source count rr_next supports
//   rr_next()          round-robin winner: first valid source above 'last', wrapping at n
package vibrometer_axis_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam int LOG_THROTTLE_WIDTH = 5;
  localparam int MAX_SOURCES        = 8;

  // Scans last+1, last+2, ... last+n (mod n). The loop runs from the far end
  // back towards last+1 so the nearest valid source is the final assignment.
  // Returns 'last' unchanged when nothing is valid; callers gate on any-valid.
  function automatic logic [2:0] rr_next(input logic [MAX_SOURCES-1:0] valid,
                                         input logic [2:0]             last,
                                         input int                     n);
    logic [2:0] win;
    logic [3:0] idx;
    win = last;
    for (int k = MAX_SOURCES; k >= 1; k--) begin
      if (k <= n) begin
        idx = {1'b0, last} + 4'(k);
        // last < n and k <= n, so one subtraction is enough to wrap
        if (idx >= 4'(n)) idx = idx - 4'(n);
        if (valid[idx[2:0]]) win = idx[2:0];
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/axis_stream_scheduler_rr_arbiter.sv
// rtl/axis_stream_scheduler_rr_arbiter.sv - round-robin selector with registered grant
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   req         per-source request vector
//   last        index of the most recently served source
//   load        capture the round-robin winner into grant this cycle
//   any_req     combinational OR of req
//   grant       registered winner index (0 after reset)
module rr_arbiter
  import vibrometer_axis_pkg::*;
#(
  parameter int NUM_SOURCES = 2,
  parameter int IDW         = $clog2(NUM_SOURCES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] req,
  input  logic [IDW-1:0]         last,
  input  logic                   load,
  output logic                   any_req,
  output logic [IDW-1:0]         grant
);

  logic [MAX_SOURCES-1:0] req_ext;
  logic [IDW-1:0]         next_grant;

  always_comb begin
    req_ext                  = '0;
    req_ext[NUM_SOURCES-1:0] = req;
    next_grant               = IDW'(rr_next(req_ext, 3'(last), NUM_SOURCES));
  end

  assign any_req = |req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant <= '0;
    end else if (load) begin
      grant <= next_grant;
    end
  end

endmodule

// File: rtl/axis_stream_scheduler.sv
// rtl/axis_stream_scheduler.sv - round-robin burst scheduler sharing one throttled AXI-Stream path
// Ports:
//   aclk, aresetn     clock, asynchronous active-low reset
//   log_throttle_req  requested throttle exponent from the register bank
//   log_throttle      exponent driven to the throttler, updated only while IDLE
//   S_AXIS_*          NUM_SOURCES slave streams, source i data at [i*W +: W]
//   M_AXIS_*          master stream to the throttler; tuser = source id,
//                     tlast marks the final beat of a burst
//   busy              high while a source holds the grant
module axis_stream_scheduler
  import vibrometer_axis_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int NUM_SOURCES      = 2,
  parameter int BURST_LENGTH     = 8,
  parameter int TIMEOUT_CYCLES   = 16
) (
  input  logic                                  aclk,
  input  logic                                  aresetn,
  input  logic [LOG_THROTTLE_WIDTH-1:0]         log_throttle_req,
  output logic [LOG_THROTTLE_WIDTH-1:0]         log_throttle,
  input  logic [NUM_SOURCES-1:0]                S_AXIS_tvalid,
  input  logic [NUM_SOURCES*AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  output logic [NUM_SOURCES-1:0]                S_AXIS_tready,
  output logic                                  M_AXIS_tvalid,
  output logic [AXIS_TDATA_WIDTH-1:0]           M_AXIS_tdata,
  input  logic                                  M_AXIS_tready,
  output logic [$clog2(NUM_SOURCES)-1:0]        M_AXIS_tuser,
  output logic                                  M_AXIS_tlast,
  output logic                                  busy
);

  localparam int IDW    = $clog2(NUM_SOURCES);
  localparam int BEAT_W = $clog2(BURST_LENGTH + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LENGTH - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_t            state;
  logic [IDW-1:0]    last_ptr;
  logic [IDW-1:0]    grant;
  logic [BEAT_W-1:0] beat_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              any_req;
  logic              arb_load;
  logic              g_valid;
  logic              hs;

  // Grant is captured on the same edge that moves IDLE -> GRANT, which is
  // what gives the single bubble cycle per burst.
  assign arb_load = (state == IDLE) && any_req;

  rr_arbiter #(
    .NUM_SOURCES (NUM_SOURCES),
    .IDW         (IDW)
  ) u_arb (
    .clk     (aclk),
    .rst_n   (aresetn),
    .req     (S_AXIS_tvalid),
    .last    (last_ptr),
    .load    (arb_load),
    .any_req (any_req),
    .grant   (grant)
  );

  assign g_valid = S_AXIS_tvalid[grant];
  assign hs      = M_AXIS_tvalid && M_AXIS_tready;
  assign busy    = (state == GRANT);

  // Pass-through mux; everything facing the streams is zero outside GRANT.
  always_comb begin
    M_AXIS_tvalid = 1'b0;
    M_AXIS_tdata  = '0;
    M_AXIS_tuser  = '0;
    M_AXIS_tlast  = 1'b0;
    S_AXIS_tready = '0;
    if (state == GRANT) begin
      M_AXIS_tvalid        = g_valid;
      M_AXIS_tdata         = S_AXIS_tdata[grant*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
      M_AXIS_tuser         = grant;
      M_AXIS_tlast         = (beat_cnt == BEAT_LAST);
      S_AXIS_tready[grant] = M_AXIS_tready;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      last_ptr     <= IDW'(NUM_SOURCES - 1);
      beat_cnt     <= '0;
      to_cnt       <= '0;
      log_throttle <= '0;
    end else begin
      case (state)
        IDLE: begin
          // Only place the exponent may change, so a burst never sees two ratios.
          log_throttle <= log_throttle_req;
          beat_cnt     <= '0;
          to_cnt       <= '0;
          if (any_req) state <= GRANT;
        end
        GRANT: begin
          if (hs) begin
            to_cnt <= '0;
            if (M_AXIS_tlast) begin
              last_ptr <= grant;
              beat_cnt <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end else if (!g_valid) begin
            // Only an idle source counts toward revocation; downstream
            // back-pressure with tvalid high never does.
            if (to_cnt == TO_LAST) begin
              last_ptr <= grant;
              beat_cnt <= '0;
              to_cnt   <= '0;
              state    <= IDLE;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end else begin
            to_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
